snn_omem_collector: RTL and testbench
=====================================

Name: snn_omem_collector

Overview:
- Clocked, parametrised output-spike memory for the SNN NoC; successor to the fixed 21x21, two-timestep omem endpoint.
- Accepts (timestep, address, spike) writes from the router-side packet decoder in any order and tracks completion per timestep.
- Streams each completed timestep to the host side in ascending timestep order. Each stream is a tagged beat sequence: START, then HDR(ts, layer) and DATA beats per timestep, then DONE.
- Adds out-of-order timestep support, duplicate and range checking, and concurrent collect/drain.

Parameters:
- DEPTH_R, 21, output feature map side; N = DEPTH_R*DEPTH_R entries per timestep.
- NUM_TS, 2, timesteps collected; timestep numbers are 1..NUM_TS.
- TS_W, 2, timestep field width.
- ADDR_W, 12, address width; must satisfy 2^ADDR_W >= N.
- OUT_W, 13, output data width; the spike bit is zero-extended.
- LAYER_ID, 1, constant layer index reported in HDR beats.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  write request.
- in_ready  out  1  write accepted on an edge where in_valid && in_ready.
- in_ts  in  TS_W  timestep of the write (1-based).
- in_addr  in  ADDR_W  output neuron address.
- in_spike  in  1  spike value.
- out_valid  out  1  output beat valid.
- out_ready  in  1  beat consumed on an edge where out_valid && out_ready.
- out_type  out  2  beat type: 0 START, 1 HDR, 2 DATA, 3 DONE.
- out_ts  out  TS_W  timestep (HDR); 0 otherwise.
- out_layer  out  2  LAYER_ID (HDR); 0 otherwise.
- out_addr  out  ADDR_W  address (DATA); 0 otherwise.
- out_data  out  OUT_W  zero-extended spike (DATA); START and DONE carry 1.
- err_dup  out  1  sticky: a duplicate write was dropped.
- err_range  out  1  sticky: an out-of-range write was dropped.

Behaviour:
- Reset values (immediate, asynchronous):
  - All spike bits, written bits and per-timestep counters are 0.
  - FSM is in COLLECT; cur_ts = 1.
  - out_valid = 0, out_type = 0, and all out_* fields are 0.
  - err_dup = err_range = 0; in_ready = 0 while rst_n = 0.
- Storage: NUM_TS x N spike bits, NUM_TS x N written bits, and NUM_TS counters of width clog2(N+1).
- Write path:
  - in_ready = 1 in every state except FIN.
  - On accept with 1 <= in_ts <= NUM_TS, in_addr < N and the written bit clear: store the spike, set the written bit, and increment that timestep's counter.
  - Written bit already set: drop the write (first write wins) and set err_dup. The counter is unchanged.
  - in_ts = 0, in_ts > NUM_TS, or in_addr >= N: drop the write and set err_range.
  - Writes to any timestep, including the one being drained, are legal in the same cycle as output beats.
- complete(t) is true when counter[t] == N.
- FSM states: COLLECT, START, HDR, DATA, DONE, FIN. Outputs are decoded from registered state only, with no combinational path from in_* to out_*.
- COLLECT:
  - out_valid = 0.
  - If complete(cur_ts): go to START when cur_ts == 1 and START has not yet been sent; otherwise go to HDR.
  - Latency: a write accepted at edge E that completes cur_ts causes the transition at edge E+1. out_valid is high in the cycle after E+1.
- START: one beat (type 0, data 1); on handshake go to HDR.
- HDR: one beat (type 1, out_ts = cur_ts, out_layer = LAYER_ID); on handshake set rd_addr = 0 and go to DATA.
- DATA:
  - Beat (type 2, out_addr = rd_addr, out_data = spike[cur_ts][rd_addr]).
  - On handshake increment rd_addr; after the handshake at rd_addr == N-1, advance cur_ts.
  - Then: if cur_ts was NUM_TS, go to DONE; else if complete(next ts), go directly to HDR; else go to COLLECT.
- DONE: one beat (type 3, data 1); on handshake go to FIN.
- FIN: out_valid = 0 and in_ready = 0; the block holds until reset.
- Output stability: while out_valid && !out_ready, every out_* field holds steady. No beat is dropped or repeated.
- Timestep ordering: a timestep that completes before its predecessor is buffered and emitted only after all lower timesteps.
- Reset mid-stream: aborts immediately; the next stream restarts with START.

Test Plan:
- In-order load: all 441 ts=1 writes, then 441 ts=2 writes, random spikes, out_ready = 1. Required: START; HDR(1,1); DATA addr 0..440 matching the golden values; HDR(2,1); 441 DATA; DONE. Total 886 beats, err flags 0.
- Out-of-order load: all ts=2 writes first. Required: out_valid stays 0. After the last ts=1 write, START appears 1 cycle after the completing acceptance edge, followed by the ts=1 stream and then the ts=2 stream with no COLLECT gap.
- Backpressure: out_ready driven by a 30%-duty random pattern. Required: each beat is held stable until handshake, and the beat sequence is identical to the in-order case.
- Duplicate write: ts=1 addr=5 with spike 1, then addr=5 with spike 0. Required: err_dup = 1, addr 5 reads back 1, and ts=1 still needs 441 distinct addresses to complete.
- Range errors: writes with addr=441 and with ts=3. Required: err_range = 1, no storage change, counters unchanged.
- Reset mid-drain: assert rst_n = 0 at DATA addr 100. Required: out_valid = 0 immediately; after reload, the stream restarts with START and addr 0.

Source files
------------

// File: rtl/snn_omem_collector.sv
// Output-spike collector for the SNN NoC: gathers (ts, addr, spike) writes in
// any order, tracks per-timestep completion, and streams finished timesteps
// to the host as START / HDR / DATA... / DONE beats in ascending ts order.
module snn_omem_collector #(
    parameter int DEPTH_R  = 21,
    parameter int NUM_TS   = 2,
    parameter int TS_W     = 2,
    parameter int ADDR_W   = 12,
    parameter int OUT_W    = 13,
    parameter int LAYER_ID = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [TS_W-1:0]   in_ts,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              in_spike,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_type,
    output logic [TS_W-1:0]   out_ts,
    output logic [1:0]        out_layer,
    output logic [ADDR_W-1:0] out_addr,
    output logic [OUT_W-1:0]  out_data,
    output logic              err_dup,
    output logic              err_range
);
    localparam int N     = DEPTH_R * DEPTH_R;
    localparam int CNT_W = $clog2(N + 1);
    localparam int IA_W  = (N > 1) ? $clog2(N) : 1;
    localparam int TI_W  = (NUM_TS > 1) ? $clog2(NUM_TS) : 1;

    typedef enum logic [2:0] {
        S_COLLECT, S_START, S_HDR, S_DATA, S_DONE, S_FIN
    } state_t;

    logic [NUM_TS-1:0][N-1:0] spike_mem;
    logic [NUM_TS-1:0][N-1:0] wr_mem;
    logic [CNT_W-1:0]         cnt [NUM_TS];

    state_t            state;
    logic [TS_W-1:0]   cur_ts;
    logic [ADDR_W-1:0] rd_addr;

    // Write-side decode: timesteps are 1-based, storage is 0-based.
    logic [TS_W-1:0] wr_ts_m1;
    logic [TS_W-1:0] cur_ts_m1;
    logic [TI_W-1:0] wr_idx;
    logic [TI_W-1:0] cur_idx;
    logic [TI_W-1:0] nxt_idx;
    logic [IA_W-1:0] wr_a;
    logic [IA_W-1:0] rd_a;
    logic            ts_ok;
    logic            addr_ok;
    logic            cur_done;
    logic            nxt_done;

    assign wr_ts_m1  = in_ts - 1'b1;
    assign cur_ts_m1 = cur_ts - 1'b1;
    assign wr_idx    = wr_ts_m1[TI_W-1:0];
    assign cur_idx   = cur_ts_m1[TI_W-1:0];
    assign nxt_idx   = cur_ts[TI_W-1:0];
    assign wr_a      = in_addr[IA_W-1:0];
    assign rd_a      = rd_addr[IA_W-1:0];
    assign ts_ok     = (in_ts != '0) && (in_ts <= TS_W'(NUM_TS));
    assign addr_ok   = in_addr < ADDR_W'(N);
    assign cur_done  = cnt[cur_idx] == CNT_W'(N);
    // Only consulted when cur_ts < NUM_TS, so nxt_idx is always in range there.
    assign nxt_done  = cnt[nxt_idx] == CNT_W'(N);

    // Writes are accepted until the final DONE beat has been taken.
    assign in_ready = rst_n && (state != S_FIN);

    // Storage update: first write per (ts, addr) wins; bad writes only flag errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_mem <= '0;
            wr_mem    <= '0;
            err_dup   <= 1'b0;
            err_range <= 1'b0;
            for (int i = 0; i < NUM_TS; i++) cnt[i] <= '0;
        end else if (in_valid && in_ready) begin
            if (!(ts_ok && addr_ok)) begin
                err_range <= 1'b1;
            end else if (wr_mem[wr_idx][wr_a]) begin
                err_dup <= 1'b1;
            end else begin
                spike_mem[wr_idx][wr_a] <= in_spike;
                wr_mem[wr_idx][wr_a]    <= 1'b1;
                cnt[wr_idx]             <= cnt[wr_idx] + 1'b1;
            end
        end
    end

    // Stream sequencer: waits for cur_ts to complete, then walks HDR and DATA beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_COLLECT;
            cur_ts  <= TS_W'(1);
            rd_addr <= '0;
        end else begin
            case (state)
                S_COLLECT: if (cur_done) state <= (cur_ts == TS_W'(1)) ? S_START : S_HDR;
                S_START:   if (out_ready) state <= S_HDR;
                S_HDR: if (out_ready) begin
                    rd_addr <= '0;
                    state   <= S_DATA;
                end
                S_DATA: if (out_ready) begin
                    if (rd_addr == ADDR_W'(N - 1)) begin
                        rd_addr <= '0;
                        if (cur_ts == TS_W'(NUM_TS)) begin
                            state <= S_DONE;
                        end else begin
                            // A later timestep that finished early chains straight on.
                            cur_ts <= cur_ts + 1'b1;
                            state  <= nxt_done ? S_HDR : S_COLLECT;
                        end
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                S_DONE:  if (out_ready) state <= S_FIN;
                S_FIN:   state <= S_FIN;
                default: state <= S_COLLECT;
            endcase
        end
    end

    // Beat fields come only from registered state, so they hold under backpressure.
    always_comb begin
        out_valid = 1'b0;
        out_type  = 2'd0;
        out_ts    = '0;
        out_layer = 2'd0;
        out_addr  = '0;
        out_data  = '0;
        case (state)
            S_START: begin
                out_valid = 1'b1;
                out_type  = 2'd0;
                out_data  = OUT_W'(1);
            end
            S_HDR: begin
                out_valid = 1'b1;
                out_type  = 2'd1;
                out_ts    = cur_ts;
                out_layer = 2'(LAYER_ID);
            end
            S_DATA: begin
                out_valid = 1'b1;
                out_type  = 2'd2;
                out_addr  = rd_addr;
                out_data  = OUT_W'(spike_mem[cur_idx][rd_a]);
            end
            S_DONE: begin
                out_valid = 1'b1;
                out_type  = 2'd3;
                out_data  = OUT_W'(1);
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_snn_omem_collector.sv
// Directed bench for snn_omem_collector: in-order, out-of-order, backpressure,
// duplicate/range errors and reset in the middle of a drain.
module tb_snn_omem_collector;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_ts;
    logic [11:0] in_addr;
    logic        in_spike;
    logic        out_valid;
    bit          out_ready;
    logic [1:0]  out_type;
    logic [1:0]  out_ts;
    logic [1:0]  out_layer;
    logic [11:0] out_addr;
    logic [12:0] out_data;
    logic        err_dup;
    logic        err_range;

    snn_omem_collector dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_ts(in_ts),
        .in_addr(in_addr), .in_spike(in_spike),
        .out_valid(out_valid), .out_ready(out_ready), .out_type(out_type),
        .out_ts(out_ts), .out_layer(out_layer), .out_addr(out_addr),
        .out_data(out_data), .err_dup(err_dup), .err_range(err_range)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit gold [2][441];
    logic [30:0] q[$];
    int qc[$];
    int cyc = 0;
    bit bp_mode = 1'b0;
    bit ready_lvl = 1'b0;
    bit stall_prev = 1'b0;
    logic [30:0] prev_beat;
    logic [30:0] beat;
    int c;
    bit found;

    assign beat = {out_type, out_ts, out_layer, out_addr, out_data};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [30:0] mk(int ty, int ts, int ly, int ad, int dt);
        return {2'(ty), 2'(ts), 2'(ly), 12'(ad), 13'(dt)};
    endfunction

    // Expected beat i of a full 886-beat stream built from gold.
    function automatic logic [30:0] exp_beat(int i);
        int j, t, k;
        if (i == 0) return mk(0, 0, 0, 0, 1);
        if (i == 885) return mk(3, 0, 0, 0, 1);
        j = i - 1;
        t = j / 442;
        k = j % 442;
        if (k == 0) return mk(1, t + 1, 1, 0, 0);
        return mk(2, 0, 0, k - 1, int'(gold[t][k-1]));
    endfunction

    // Ready driver: fixed level or ~30% random duty.
    always @(posedge clk) begin
        #1;
        out_ready = bp_mode ? ($urandom_range(0, 9) < 3) : ready_lvl;
    end

    // Beat recorder and hold-under-stall checker, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_beat", 32'(beat), 32'(prev_beat));
            end
            if (out_valid && out_ready) begin
                q.push_back(beat);
                qc.push_back(cyc);
            end
            stall_prev = out_valid && !out_ready;
            prev_beat  = beat;
        end
    end

    task automatic wr(input int ts, input int ad, input bit sp);
        in_valid = 1'b1;
        in_ts    = 2'(ts);
        in_addr  = 12'(ad);
        in_spike = sp;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        qc.delete();
    endtask

    task automatic randomize_gold();
        for (int t = 0; t < 2; t++)
            for (int a = 0; a < 441; a++) gold[t][a] = 1'($urandom_range(0, 1));
    endtask

    task automatic load_ts(input int ts);
        for (int a = 0; a < 441; a++) wr(ts, a, gold[ts-1][a]);
        in_valid = 1'b0;
    endtask

    task automatic wait_beats(input string tag, input int n, input int bound);
        int k = 0;
        while (q.size() < n && k < bound) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk({tag, "_reached"}, 32'(q.size() >= n), 32'd1);
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_nbeats"}, 32'(q.size()), 32'd886);
        for (int i = 0; i < q.size() && i < 886; i++)
            chk($sformatf("%s_beat%0d", tag, i), 32'(q[i]), 32'(exp_beat(i)));
    endtask

    initial begin
        in_valid = 1'b0;
        in_ts    = '0;
        in_addr  = '0;
        in_spike = 1'b0;
        rst_n    = 1'b0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_err_dup", 32'(err_dup), 32'd0);
        chk("rst_err_range", 32'(err_range), 32'd0);
        chk("rst_out_type", 32'(out_type), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // In-order load with out_ready held high.
        randomize_gold();
        ready_lvl = 1'b1;
        load_ts(1);
        load_ts(2);
        wait_beats("inorder", 886, 3000);
        idle(3);
        check_stream("inorder");
        chk("inorder_err_dup", 32'(err_dup), 32'd0);
        chk("inorder_err_range", 32'(err_range), 32'd0);
        chk("fin_out_valid", 32'(out_valid), 32'd0);
        chk("fin_in_ready", 32'(in_ready), 32'd0);

        // Out-of-order: ts=2 first must stay buffered.
        do_reset();
        randomize_gold();
        load_ts(2);
        idle(5);
        chk("ooo_hold_valid", 32'(out_valid), 32'd0);
        chk("ooo_hold_beats", 32'(q.size()), 32'd0);
        for (int a = 0; a < 440; a++) wr(1, a, gold[0][a]);
        wr(1, 440, gold[0][440]);
        in_valid = 1'b0;
        chk("ooo_lat_edgeE", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("ooo_lat_valid", 32'(out_valid), 32'd1);
        chk("ooo_lat_type", 32'(out_type), 32'd0);
        wait_beats("ooo", 886, 3000);
        idle(3);
        check_stream("ooo");
        if (q.size() == 886) chk("ooo_no_gap", 32'(qc[885] - qc[0]), 32'd885);

        // Backpressure with random ready.
        do_reset();
        randomize_gold();
        bp_mode = 1'b1;
        load_ts(1);
        load_ts(2);
        wait_beats("bp", 886, 20000);
        bp_mode = 1'b0;
        idle(3);
        check_stream("bp");

        // Duplicate and range errors.
        ready_lvl = 1'b0;
        idle(2);
        do_reset();
        randomize_gold();
        gold[0][5] = 1'b1;
        gold[1][0] = 1'b0;
        wr(1, 5, 1'b1);
        wr(1, 5, 1'b0);
        idle(1);
        chk("dup_err_dup", 32'(err_dup), 32'd1);
        chk("dup_err_range", 32'(err_range), 32'd0);
        for (int a = 0; a < 440; a++) if (a != 5) wr(1, a, gold[0][a]);
        idle(4);
        chk("dup_not_complete", 32'(out_valid), 32'd0);
        ready_lvl = 1'b1;
        wr(1, 440, gold[0][440]);
        wait_beats("dup_ts1", 443, 2000);
        idle(3);
        wr(2, 441, 1'b1);
        wr(3, 0, 1'b1);
        wr(0, 0, 1'b1);
        idle(1);
        chk("rng_err_range", 32'(err_range), 32'd1);
        for (int a = 0; a < 440; a++) wr(2, a, gold[1][a]);
        idle(4);
        chk("rng_not_complete", 32'(out_valid), 32'd0);
        wr(2, 440, gold[1][440]);
        wait_beats("duprng", 886, 2000);
        idle(3);
        check_stream("duprng");
        if (q.size() > 7) chk("dup_addr5", 32'(q[7]), 32'(mk(2, 0, 0, 5, 1)));

        // Reset in the middle of a drain.
        ready_lvl = 1'b0;
        idle(2);
        do_reset();
        randomize_gold();
        load_ts(1);
        ready_lvl = 1'b1;
        c = 0;
        found = 1'b0;
        while (!found && c < 2000) begin
            @(negedge clk);
            c++;
            if (out_valid && out_type == 2'd2 && out_addr == 12'd100) found = 1'b1;
        end
        chk("mid_found_addr100", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_type", 32'(out_type), 32'd0);
        do_reset();
        randomize_gold();
        load_ts(1);
        load_ts(2);
        wait_beats("mid", 886, 3000);
        idle(3);
        if (q.size() > 2) begin
            chk("mid_first_start", 32'(q[0]), 32'(mk(0, 0, 0, 0, 1)));
            chk("mid_first_addr0", 32'(q[2]), 32'(mk(2, 0, 0, 0, int'(gold[0][0]))));
        end
        check_stream("mid");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
